// File: rtl/score_display_ctrl_pkg.sv
// Shared types and constants for the on-screen score display controller.
package score_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        COMMIT
    } state_t;

    localparam int          NUM_PLACES = 6;
    localparam logic [19:0] SCORE_MAX  = 20'd999999;
    localparam int          BCD_ITERS  = 20;

    // Placement and size of the digit row on screen, in pixels.
    localparam logic [9:0]  X0      = 10'd20;
    localparam logic [9:0]  Y0      = 10'd20;
    localparam int          DIGIT_W = 30;
    localparam int          DIGIT_H = 30;

endpackage

// File: rtl/score_display_ctrl_if.sv
// Bundle of score-load handshake, held digits and pixel-decode signals.
interface score_display_ctrl_if;

    logic [19:0] score_in;
    logic        score_load;
    logic        busy;
    logic        done;
    logic [3:0]  display_ones;
    logic [3:0]  display_tens;
    logic [3:0]  display_hundreds;
    logic [3:0]  display_thousands;
    logic [3:0]  display_ten_thousands;
    logic [3:0]  display_hundred_thousands;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ones;
    logic        tens;
    logic        hundreds;
    logic        thousands;
    logic        ten_thousands;
    logic        hundred_thousands;
    logic [14:0] ADDR;
    logic        in_region;

    // Game-state / scan-counter side.
    modport master (
        output score_in, score_load, x, y,
        input  busy, done,
        input  display_ones, display_tens, display_hundreds,
        input  display_thousands, display_ten_thousands, display_hundred_thousands,
        input  ones, tens, hundreds, thousands, ten_thousands, hundred_thousands,
        input  ADDR, in_region
    );

    // Controller side.
    modport slave (
        input  score_in, score_load, x, y,
        output busy, done,
        output display_ones, display_tens, display_hundreds,
        output display_thousands, display_ten_thousands, display_hundred_thousands,
        output ones, tens, hundreds, thousands, ten_thousands, hundred_thousands,
        output ADDR, in_region
    );

endinterface

// File: rtl/score_display_ctrl_bin2bcd.sv
// Shift-add-3 binary to BCD datapath with held display digits.
// Optional LEADING_ZERO_BLANK_EN: registers a leading-zero blank mask with the digits.
module bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] score_in,
    input  logic        capture,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        commit,
    output logic        last_iter,
    output logic [23:0] digits,
    output logic [5:0]  blank_mask
);

    logic [19:0] bin_p0;
    logic [23:0] bcd_p0;
    logic [23:0] bcd_adj;
    logic [4:0]  cnt_p0;

    function automatic logic [19:0] sat_score(input logic [19:0] v);
        return (v > SCORE_MAX) ? SCORE_MAX : v;
    endfunction

    function automatic logic [23:0] add3(input logic [23:0] b);
        logic [23:0] r;
        r = b;
        for (int i = 0; i < NUM_PLACES; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj   = add3(bcd_p0);
    assign last_iter = (cnt_p0 == 5'(BCD_ITERS - 1));

    // Working registers: capture/clamp the score, then adjust-and-shift per iteration.
    always_ff @(posedge clk) begin
        if (capture)
            bin_p0 <= sat_score(score_in);
        else if (shift_en)
            bin_p0 <= {bin_p0[18:0], 1'b0};

        if (clear) begin
            bcd_p0 <= '0;
            cnt_p0 <= '0;
        end else if (shift_en) begin
            bcd_p0 <= {bcd_adj[22:0], bin_p0[19]};
            cnt_p0 <= cnt_p0 + 5'd1;
        end
    end

    // Displayed digits change only on commit so a frame never shows a partial value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            digits <= '0;
        else if (commit)
            digits <= bcd_p0;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Bit k blanks place k (0 = hundred_thousands); ones (bit 5) is never blanked.
    function automatic logic [5:0] lead_blank(input logic [23:0] d);
        logic [5:0] m;
        logic       seen;
        m    = '0;
        seen = 1'b0;
        for (int k = 0; k < NUM_PLACES - 1; k++) begin
            if (d[23 - 4*k -: 4] != 4'd0)
                seen = 1'b1;
            m[k] = !seen;
        end
        return m;
    endfunction

    // Blank mask registered alongside the digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            blank_mask <= 6'b011111;
        else if (commit)
            blank_mask <= lead_blank(bcd_p0);
    end
`else
    assign blank_mask = '0;
`endif

endmodule

// File: rtl/score_display_ctrl.sv
// Score display controller: sequences BCD conversion and decodes scan position
// into a one-hot place select plus glyph-local ROM address.
// Optional feature macro: LEADING_ZERO_BLANK_EN.
module score_display_ctrl
    import score_display_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    score_display_ctrl_if.slave bus
);

    localparam logic signed [10:0] ROW_W = 11'(NUM_PLACES * DIGIT_W);
    localparam logic signed [10:0] ROW_H = 11'(DIGIT_H);

    state_t      state, state_nxt;
    logic        clear, shift_en, commit, last_iter;
    logic        busy_q, done_q;
    logic [23:0] digits;
    logic [5:0]  blank_mask;

    logic signed [10:0] dx_p0, dy_p0;
    logic               in_row_p0;
    logic [5:0]         sel_p0;
    logic [4:0]         off_p0;
    logic [14:0]        addr_p0;
    logic [5:0]         sel_p1;
    logic [14:0]        addr_p1;
    logic               region_p1;

    bin2bcd_seq u_bcd (
        .clk        (clk),
        .reset      (reset),
        .score_in   (bus.score_in),
        .capture    (bus.score_load),
        .clear      (clear),
        .shift_en   (shift_en),
        .commit     (commit),
        .last_iter  (last_iter),
        .digits     (digits),
        .blank_mask (blank_mask)
    );

    // Converter state register plus registered busy/done flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state == LOAD) || (state == SHIFT);
            done_q <= (state == COMMIT);
        end
    end

    // Next state and datapath strobes; a new load always restarts from LOAD.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        shift_en  = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.score_load)
                    state_nxt = LOAD;
            end
            LOAD: begin
                clear     = 1'b1;
                state_nxt = bus.score_load ? LOAD : SHIFT;
            end
            SHIFT: begin
                if (bus.score_load) begin
                    state_nxt = LOAD;
                end else begin
                    shift_en = 1'b1;
                    if (last_iter)
                        state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = bus.score_load ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 0: row test, six-way column compare and glyph-local address.
    always_comb begin
        dx_p0     = $signed({1'b0, bus.x}) - $signed({1'b0, X0});
        dy_p0     = $signed({1'b0, bus.y}) - $signed({1'b0, Y0});
        in_row_p0 = !dx_p0[10] && (dx_p0 < ROW_W) && !dy_p0[10] && (dy_p0 < ROW_H);
        sel_p0    = '0;
        off_p0    = '0;
        addr_p0   = '0;
        if (in_row_p0) begin
            for (int k = 0; k < NUM_PLACES; k++) begin
                if (dx_p0 >= 11'(k * DIGIT_W) && dx_p0 < 11'((k + 1) * DIGIT_W)) begin
                    sel_p0[k] = 1'b1;
                    off_p0    = 5'(dx_p0 - 11'(k * DIGIT_W));
                end
            end
            addr_p0 = 15'(dy_p0[4:0]) * 15'(DIGIT_W) + 15'(off_p0);
        end
    end

    // Stage 1: registered pixel outputs, blank mask applied to the selects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_p1    <= '0;
            addr_p1   <= '0;
            region_p1 <= 1'b0;
        end else begin
            sel_p1    <= sel_p0 & ~blank_mask;
            addr_p1   <= addr_p0;
            region_p1 <= |(sel_p0 & ~blank_mask);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    assign bus.display_hundred_thousands = digits[23:20];
    assign bus.display_ten_thousands     = digits[19:16];
    assign bus.display_thousands         = digits[15:12];
    assign bus.display_hundreds          = digits[11:8];
    assign bus.display_tens              = digits[7:4];
    assign bus.display_ones              = digits[3:0];

    assign bus.hundred_thousands = sel_p1[0];
    assign bus.ten_thousands     = sel_p1[1];
    assign bus.thousands         = sel_p1[2];
    assign bus.hundreds          = sel_p1[3];
    assign bus.tens              = sel_p1[4];
    assign bus.ones              = sel_p1[5];
    assign bus.ADDR              = addr_p1;
    assign bus.in_region         = region_p1;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: conversion timing, saturation,
// restart, reset abort and pixel decode (with or without leading-zero blanking).
module tb_score_display_ctrl;

    localparam int X0 = 20;
    localparam int Y0 = 20;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;
    int   lat;
    logic seen_done;
    logic [5:0] exp42;
    logic [5:0] exp0;

    score_display_ctrl_if bus ();

    score_display_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_score(input logic [19:0] v);
        bus.score_in   = v;
        bus.score_load = 1'b1;
        tick();
        bus.score_load = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.done) begin
                l = i;
                break;
            end
        end
    endtask

    function automatic logic [23:0] digits();
        return {bus.display_hundred_thousands, bus.display_ten_thousands,
                bus.display_thousands, bus.display_hundreds,
                bus.display_tens, bus.display_ones};
    endfunction

    function automatic logic [5:0] sel_vec();
        return {bus.ones, bus.tens, bus.hundreds, bus.thousands,
                bus.ten_thousands, bus.hundred_thousands};
    endfunction

    task automatic set_pos(input int px, input int py);
        bus.x = 10'(px);
        bus.y = 10'(py);
    endtask

    task automatic scan_row(input string tag, input logic [5:0] mask);
        for (int k = 0; k < 6; k++) begin
            set_pos(X0 + k * 30 + 15, Y0 + 5);
            tick();
            chk(tag, 32'(sel_vec()), mask[k] ? 32'(1 << k) : 32'd0);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
`ifdef LEADING_ZERO_BLANK_EN
        exp42 = 6'b110000;
        exp0  = 6'b100000;
`else
        exp42 = 6'b111111;
        exp0  = 6'b111111;
`endif
        reset          = 1'b1;
        bus.score_in   = '0;
        bus.score_load = 1'b0;
        set_pos(X0 + 31, Y0 + 2);
        tick();
        tick();

        // Reset state: pixel registers held in reset even with an in-row position.
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_digits", 32'(digits()), 0);
        chk("rst_sel", 32'(sel_vec()), 0);
        chk("rst_addr", 32'(bus.ADDR), 0);
        chk("rst_region", 32'(bus.in_region), 0);
        reset = 1'b0;
        set_pos(0, 0);
        tick();

        // 123456: busy for edges 1..21, done and digits at edge 22.
        load_score(20'd123456);
        chk("busy_e0", 32'(bus.busy), 0);
        for (int i = 1; i <= 21; i++) begin
            tick();
            chk("busy_done_run", 32'({bus.busy, bus.done}), 32'b10);
            if (i == 21)
                chk("digits_hold", 32'(digits()), 0);
        end
        tick();
        chk("done_e22", 32'(bus.done), 1);
        chk("busy_e22", 32'(bus.busy), 0);
        chk("digits_123456", 32'(digits()), 32'h123456);
        tick();
        chk("done_pulse", 32'(bus.done), 0);

        // Saturation above 999999.
        load_score(20'd1000000);
        wait_done(lat);
        chk("lat_sat", 32'(lat), 22);
        chk("digits_sat", 32'(digits()), 32'h999999);

        // 42: pixel decode.
        load_score(20'd42);
        wait_done(lat);
        chk("lat_42", 32'(lat), 22);
        chk("digits_42", 32'(digits()), 32'h000042);
        set_pos(X0 + 31, Y0 + 2);
        tick();
        chk("sel_tt", 32'(sel_vec()), exp42[1] ? 32'b000010 : 32'd0);
        chk("addr_61", 32'(bus.ADDR), 61);
        chk("region_tt", 32'(bus.in_region), 32'(exp42[1]));
        set_pos(X0 + 179, Y0 + 29);
        tick();
        chk("sel_ones_corner", 32'(sel_vec()), 32'b100000);
        chk("addr_899", 32'(bus.ADDR), 899);
        set_pos(X0 + 180, Y0 + 29);
        #1;
        chk("region_latency", 32'(bus.in_region), 1);
        tick();
        chk("sel_right_out", 32'(sel_vec()), 0);
        chk("addr_right_out", 32'(bus.ADDR), 0);
        chk("region_right_out", 32'(bus.in_region), 0);
        set_pos(X0 - 1, Y0);
        tick();
        chk("sel_left_out", 32'(sel_vec()), 0);
        set_pos(X0 + 5, Y0 + 30);
        tick();
        chk("sel_below_out", 32'(sel_vec()), 0);
        chk("addr_below_out", 32'(bus.ADDR), 0);
        set_pos(X0 + 60, Y0 + 1);
        tick();
        chk("addr_th_origin", 32'(bus.ADDR), 30);
        scan_row("scan_42", exp42);

        // 0: only the ones place survives blanking.
        load_score(20'd0);
        wait_done(lat);
        chk("digits_0", 32'(digits()), 0);
        scan_row("scan_0", exp0);

        // Restart: 555 then 777 ten edges later; only the second completes.
        load_score(20'd555);
        seen_done = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            seen_done |= bus.done;
        end
        chk("restart_no_early_done", 32'(seen_done), 0);
        load_score(20'd777);
        chk("restart_digits_kept", 32'(digits()), 0);
        wait_done(lat);
        chk("lat_restart", 32'(lat), 22);
        chk("digits_777", 32'(digits()), 32'h000777);

        // Reset mid-conversion aborts with no done pulse.
        load_score(20'd999);
        for (int i = 1; i <= 7; i++)
            tick();
        reset = 1'b1;
        #2;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_digits", 32'(digits()), 0);
        chk("abort_done", 32'(bus.done), 0);
        tick();
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            seen_done |= bus.done;
        end
        chk("abort_no_done", 32'(seen_done), 0);
        chk("abort_idle_busy", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
